// File: rtl/serpent_round_engine.sv
// Iterative Serpent encrypt/decrypt core: UNROLL rounds per clock with internal key
// mixing; subkeys are fetched externally by round index every RUN cycle.
module serpent_round_engine #(
    parameter int unsigned UNROLL = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_decrypt,
    input  logic [127:0]            i_data,
    output logic [5:0]              o_key_idx,
    input  logic [128*UNROLL-1:0]   i_subkeys,
    input  logic [127:0]            i_key32,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [127:0]            o_data
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("serpent_round_engine: UNROLL must be 1, 2, 4 or 8");
    end

    localparam int unsigned NCYC = 32 / UNROLL;
    localparam logic [4:0]  LAST = 5'(NCYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] x_q, x_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         dec_q, dec_d;
    logic         valid_q, valid_d;
    logic [127:0] out_q, out_d;
    logic [5:0]   key_base;
    logic [127:0] enc_x, dec_x;

    function automatic logic [31:0] rol(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Table nibble v holds S[v]; word0 supplies bit 0 of each bitslice nibble.
    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [3:0] x);
        logic [63:0] t;
        case (box)
            3'd0:    t = 64'hC907_24DE_B56A_1F83;
            3'd1:    t = 64'h43D6_8EB1_A509_72CF;
            3'd2:    t = 64'h25B0_4E1D_FAC3_9768;
            3'd3:    t = 64'hE57A_421D_369C_8BF0;
            3'd4:    t = 64'hD7E9_A452_6B0C_38F1;
            3'd5:    t = 64'h176D_8E30_C9A4_B25F;
            3'd6:    t = 64'h0A3D_F19E_B648_5C27;
            default: t = 64'h6539_AC47_B28E_0FD1;
        endcase
        return t[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] isbox(input logic [2:0] box, input logic [3:0] y);
        logic [3:0] res;
        res = '0;
        for (int unsigned v = 0; v < 16; v++)
            if (sbox(box, 4'(v)) == y) res = 4'(v);
        return res;
    endfunction

    function automatic logic [127:0] sub_layer(input logic [2:0] box, input logic [127:0] x,
                                               input logic inv);
        logic [127:0] y;
        logic [3:0]   n, m;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = {x[96+i], x[64+i], x[32+i], x[i]};
            m = inv ? isbox(box, n) : sbox(box, n);
            y[i]    = m[0];
            y[32+i] = m[1];
            y[64+i] = m[2];
            y[96+i] = m[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] lt(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {d, c, b, a} = x;
        a = rol(a, 13);
        c = rol(c, 3);
        b = b ^ a ^ c;
        d = d ^ c ^ (a << 3);
        b = rol(b, 1);
        d = rol(d, 7);
        a = a ^ b ^ d;
        c = c ^ d ^ (b << 7);
        a = rol(a, 5);
        c = rol(c, 22);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] ilt(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {d, c, b, a} = x;
        c = rol(c, 32 - 22);
        a = rol(a, 32 - 5);
        c = c ^ d ^ (b << 7);
        a = a ^ b ^ d;
        d = rol(d, 32 - 7);
        b = rol(b, 32 - 1);
        d = d ^ c ^ (a << 3);
        b = b ^ a ^ c;
        c = rol(c, 32 - 3);
        a = rol(a, 32 - 13);
        return {d, c, b, a};
    endfunction

    always_comb begin
        if (dec_q) key_base = 6'(32 - (int'(cnt_q) + 1) * int'(UNROLL));
        else       key_base = 6'(int'(cnt_q) * int'(UNROLL));
    end

    // Decrypt walks the fetched slices top-down; the round-31 slot also absorbs K32.
    always_comb begin
        logic [5:0]   r;
        logic [127:0] k;
        r     = '0;
        k     = '0;
        enc_x = x_q;
        dec_x = x_q;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            r     = key_base + 6'(j);
            k     = i_subkeys[j*128 +: 128];
            enc_x = sub_layer(r[2:0], enc_x ^ k, 1'b0);
            enc_x = (r == 6'd31) ? (enc_x ^ i_key32) : lt(enc_x);
        end
        for (int unsigned j = UNROLL; j > 0; j--) begin
            r = key_base + 6'(j - 1);
            k = i_subkeys[(j-1)*128 +: 128];
            if (r == 6'd31) dec_x = sub_layer(3'd7, dec_x ^ i_key32, 1'b1);
            else            dec_x = sub_layer(r[2:0], ilt(dec_x), 1'b1);
            dec_x = dec_x ^ k;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    x_d     = i_data;
                    dec_d   = i_decrypt;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = dec_q ? dec_x : enc_x;
                if (cnt_q == LAST) state_d = DONE;
                else               cnt_d   = cnt_q + 5'd1;
            end
            DONE: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    out_d   = x_q;
                end else if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = valid_q;
    assign o_data    = out_q;
    assign o_key_idx = (state_q == RUN) ? key_base : '0;

endmodule
